// File: rtl/uartbone_pkg.sv
// Shared constants and FSM state encoding for the UART-to-Wishbone debug master.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uartbone_pkg;
    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam int         ADDR_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_ADDR,
        ST_WDATA,
        ST_WB_WR,
        ST_WB_RD,
        ST_TX_WORD
    } state_t;
endpackage

// File: rtl/uartbone_phy.sv
// 8N1 UART RX/TX engines with 2-flop rx synchroniser and per-bit baud counters.
// Latency: rx byte valid at mid stop bit; tx start bit begins the edge after accept.
// Backpressure: rx byte held until rx_rdy (overwritten by next byte); tx_rdy low while shifting.
module uartbone_phy #(
    parameter int CLK_DIV = 347
) (
    input  logic       core_clk,
    input  logic       core_rstn,
    input  logic       enable,
    input  logic       rx_pin,
    output logic       tx_pin,
    output logic [7:0] rx_dat,
    output logic       rx_vld,
    input  logic       rx_rdy,
    output logic       frame_err,
    input  logic [7:0] tx_dat,
    input  logic       tx_vld,
    output logic       tx_rdy
);
    localparam logic [15:0] BIT_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

    logic [1:0]  rx_sync;
    logic        rx_s, rx_prev, rx_busy;
    logic [15:0] rx_cnt;
    logic [3:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        tx_busy;
    logic [15:0] tx_cnt;
    logic [3:0]  tx_bit;
    logic [8:0]  tx_shift;

    assign rx_s   = rx_sync[1];
    assign tx_rdy = ~tx_busy;

    always_ff @(posedge core_clk) begin
        if (!core_rstn || !enable) begin
            rx_sync   <= 2'b11;
            rx_prev   <= 1'b1;
            rx_busy   <= 1'b0;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_dat    <= '0;
            rx_vld    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_sync   <= {rx_sync[0], rx_pin};
            rx_prev   <= rx_s;
            frame_err <= 1'b0;
            if (rx_vld && rx_rdy) rx_vld <= 1'b0;
            if (!rx_busy) begin
                if (rx_prev && !rx_s) begin
                    rx_busy <= 1'b1;
                    rx_cnt  <= HALF_LAST;
                    rx_bit  <= '0;
                end
            end else if (rx_cnt != 16'd0) begin
                rx_cnt <= rx_cnt - 16'd1;
            end else begin
                rx_cnt <= BIT_LAST;
                rx_bit <= rx_bit + 4'd1;
                // bit 0 is the start-bit recheck, 1..8 data, 9 stop
                if (rx_bit == 4'd0) begin
                    if (rx_s) rx_busy <= 1'b0;
                end else if (rx_bit < 4'd9) begin
                    rx_shift <= {rx_s, rx_shift[7:1]};
                end else begin
                    rx_busy <= 1'b0;
                    if (rx_s) begin
                        rx_dat <= rx_shift;
                        rx_vld <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge core_clk) begin
        if (!core_rstn || !enable) begin
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '1;
            tx_pin   <= 1'b1;
        end else if (!tx_busy) begin
            if (tx_vld) begin
                tx_busy  <= 1'b1;
                tx_cnt   <= BIT_LAST;
                tx_bit   <= '0;
                tx_shift <= {1'b1, tx_dat};
                tx_pin   <= 1'b0;
            end
        end else if (tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
        end else begin
            tx_cnt <= BIT_LAST;
            if (tx_bit == 4'd9) begin
                tx_busy <= 1'b0;
                tx_pin  <= 1'b1;
            end else begin
                tx_pin   <= tx_shift[0];
                tx_shift <= {1'b1, tx_shift[8:1]};
                tx_bit   <= tx_bit + 4'd1;
            end
        end
    end
endmodule

// File: rtl/uartbone_debug_master.sv
// UART-framed read/write burst commands executed as classic Wishbone master cycles.
// Latency: bus cycle issued one edge after the last byte of a word; read word tx starts one edge after ack.
// Backpressure: rx bytes held in the phy during a write cycle, discarded during read/tx; one word in flight.
module uartbone_debug_master #(
    parameter int CLK_DIV    = 347,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 30,
    parameter int MAX_BURST  = 255,
    parameter int RX_TIMEOUT = 16 * CLK_DIV * 10,
    parameter int WB_TIMEOUT = 1024
) (
    input  logic                    core_clk,
    input  logic                    core_rstn,
    input  logic                    debug_enable,
    input  logic                    debug_in,
    output logic                    debug_out,
    output logic                    debug_oeb,
    output logic                    wbm_cyc_o,
    output logic                    wbm_stb_o,
    output logic                    wbm_we_o,
    output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
    output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    input  logic                    wbm_ack_i,
    input  logic                    wbm_err_i,
    output logic                    busy,
    output logic                    err_sticky
);
    import uartbone_pkg::*;

    localparam logic [3:0]  NB_L    = 4'(DATA_WIDTH / 8);
    localparam logic [3:0]  ADDR_L  = 4'(ADDR_BYTES - 1);
    localparam logic [7:0]  MAX_LEN = 8'(MAX_BURST);
    localparam logic [31:0] RX_LIM  = 32'(RX_TIMEOUT);
    localparam logic [31:0] WB_LIM  = 32'(WB_TIMEOUT - 1);

    state_t                  state;
    logic [7:0]              rx_dat, len_cnt;
    logic                    rx_vld, rx_rdy, tx_vld, tx_rdy, frame_err, is_write;
    logic [3:0]              idx;
    logic [31:0]             timer;
    logic [ADDR_WIDTH-1:0]   cur_adr;
    logic [DATA_WIDTH-1:0]   data_sh;

    assign busy   = (state != ST_IDLE);
    assign rx_rdy = (state != ST_WB_WR);
    assign tx_vld = (state == ST_TX_WORD) && (idx < NB_L);

    uartbone_phy #(.CLK_DIV(CLK_DIV)) u_phy (
        .core_clk  (core_clk),
        .core_rstn (core_rstn),
        .enable    (debug_enable),
        .rx_pin    (debug_in),
        .tx_pin    (debug_out),
        .rx_dat    (rx_dat),
        .rx_vld    (rx_vld),
        .rx_rdy    (rx_rdy),
        .frame_err (frame_err),
        .tx_dat    (data_sh[DATA_WIDTH-1 -: 8]),
        .tx_vld    (tx_vld),
        .tx_rdy    (tx_rdy)
    );

    always_ff @(posedge core_clk) begin
        if (!core_rstn) debug_oeb <= 1'b1;
        else            debug_oeb <= ~debug_enable;
    end

    always_ff @(posedge core_clk) begin
        if (!core_rstn || !debug_enable) begin
            state     <= ST_IDLE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            timer     <= '0;
            idx       <= '0;
            if (!core_rstn) begin
                err_sticky <= 1'b0;
                wbm_adr_o  <= '0;
                wbm_dat_o  <= '0;
                cur_adr    <= '0;
                data_sh    <= '0;
                len_cnt    <= '0;
                is_write   <= 1'b0;
            end
        end else begin
            if (frame_err) err_sticky <= 1'b1;
            case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (rx_vld && (rx_dat == CMD_WRITE || rx_dat == CMD_READ)) begin
                        is_write <= (rx_dat == CMD_WRITE);
                        state    <= ST_LEN;
                    end
                end
                ST_LEN, ST_ADDR, ST_WDATA: begin
                    if (rx_vld) begin
                        timer <= '0;
                        idx   <= idx + 4'd1;
                        if (state == ST_LEN) begin
                            len_cnt <= (rx_dat > MAX_LEN) ? MAX_LEN : rx_dat;
                            idx     <= '0;
                            state   <= ST_ADDR;
                        end else if (state == ST_ADDR) begin
                            // upper address bits fall off the top of the shift
                            cur_adr <= {cur_adr[ADDR_WIDTH-9:0], rx_dat};
                            if (idx == ADDR_L) begin
                                idx <= '0;
                                if (len_cnt == 8'd0) state <= ST_IDLE;
                                else                 state <= is_write ? ST_WDATA : ST_WB_RD;
                            end
                        end else begin
                            data_sh <= {data_sh[DATA_WIDTH-9:0], rx_dat};
                            if (idx == NB_L - 4'd1) begin
                                idx   <= '0;
                                state <= ST_WB_WR;
                            end
                        end
                    end else if (timer == RX_LIM) begin
                        err_sticky <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                ST_WB_WR, ST_WB_RD: begin
                    if (!wbm_cyc_o) begin
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= (state == ST_WB_WR);
                        wbm_sel_o <= '1;
                        wbm_adr_o <= cur_adr;
                        if (state == ST_WB_WR) wbm_dat_o <= data_sh;
                        timer <= '0;
                    end else if (wbm_ack_i || wbm_err_i || timer == WB_LIM) begin
                        // ack has priority over a simultaneous timeout
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= '0;
                        cur_adr   <= cur_adr + ADDR_WIDTH'(1);
                        len_cnt   <= len_cnt - 8'd1;
                        idx       <= '0;
                        timer     <= '0;
                        if (!wbm_ack_i) err_sticky <= 1'b1;
                        if (state == ST_WB_RD) begin
                            data_sh <= wbm_ack_i ? wbm_dat_i : '1;
                            state   <= ST_TX_WORD;
                        end else begin
                            state <= (len_cnt == 8'd1) ? ST_IDLE : ST_WDATA;
                        end
                    end else begin
                        timer <= timer + 32'd1;
                    end
                end
                ST_TX_WORD: begin
                    if (tx_vld && tx_rdy) begin
                        data_sh <= data_sh << 8;
                        idx     <= idx + 4'd1;
                    end else if (idx == NB_L && tx_rdy) begin
                        state <= (len_cnt == 8'd0) ? ST_IDLE : ST_WB_RD;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: doc/uartbone_debug_master.md
Name: uartbone_debug_master

Overview:
- Synthesizable, parametrised UART-to-Wishbone debug master for the management core; successor to the fixed bench-side wb_rw_test UART model.
- Accepts framed read/write burst commands on the debug UART pin and runs classic Wishbone master cycles on the core bus.
- Adds configurable baud divisor, data width and burst length, inter-byte and bus-ack timeouts, and sticky error reporting.

Parameters:
- CLK_DIV, 347, core_clk cycles per UART bit (40 MHz / 115200); legal range 8..65535.
- DATA_WIDTH, 32, Wishbone data width; must be a multiple of 8, either 32 or 64.
- ADDR_WIDTH, 30, word-address width; upper address-field bits beyond this width are discarded.
- MAX_BURST, 255, largest length accepted; larger lengths are clamped to MAX_BURST.
- RX_TIMEOUT, 16*CLK_DIV*10, idle cycles allowed between command bytes before the command is dropped.
- WB_TIMEOUT, 1024, cycles to wait for ack/err before the bus cycle is abandoned.

Ports:
- core_clk  in  1  clock
- core_rstn  in  1  synchronous reset, active low
- debug_enable  in  1  bridge enable
- debug_in  in  1  UART rx, asynchronous, idle high
- debug_out  out  1  UART tx, idle high
- debug_oeb  out  1  tx output-enable bar; equals ~debug_enable
- wbm_cyc_o  out  1  Wishbone cycle
- wbm_stb_o  out  1  Wishbone strobe
- wbm_we_o  out  1  Wishbone write enable
- wbm_sel_o  out  DATA_WIDTH/8  byte select; all ones during a cycle
- wbm_adr_o  out  ADDR_WIDTH  word address
- wbm_dat_o  out  DATA_WIDTH  write data
- wbm_dat_i  in  DATA_WIDTH  read data
- wbm_ack_i  in  1  cycle acknowledge
- wbm_err_i  in  1  cycle error
- busy  out  1  high whenever the command FSM is not in IDLE
- err_sticky  out  1  set on any timeout, bus error or framing error; cleared only by reset

Behaviour:
- Reset (core_rstn low at a core_clk edge) drives every output low, except debug_out=1 and debug_oeb=1. The FSM enters IDLE and both UART engines reset.
- RX path:
  - 2-flop synchroniser on debug_in.
  - Start bit detected on a falling edge; start bit re-checked at CLK_DIV/2; data bits sampled every CLK_DIV, LSB first; 8N1 framing.
  - A low stop bit drops the byte and sets err_sticky.
- TX path: 8N1, LSB first. debug_out is held at 1 when idle or when debug_enable is low.
- Frame format: CMD(1 byte), LEN(1 byte), ADDR(4 bytes, big-endian), then data words.
  - CMD 0x01 is write; CMD 0x02 is read. Any other CMD byte is ignored and the FSM stays in IDLE.
  - Each data word is DATA_WIDTH/8 bytes, big-endian.
- FSM states: IDLE -> LEN -> ADDR -> {WDATA -> WB_WR | WB_RD -> TX_WORD} -> IDLE.
- Write burst: each complete word starts a single WB write at the current address. The address increments by 1 per word and wraps modulo 2^ADDR_WIDTH. The FSM returns to IDLE after LEN words.
- Read burst: WB read at the current address, then the word is shifted out on TX, MSB byte first. The address increments and the sequence repeats LEN times. No bus cycle overlaps TX.
- Bus cycle handshake:
  - cyc/stb/we/adr/dat are registered and asserted together.
  - They are held until ack, err or timeout; cyc and stb deassert on the next edge.
  - Read data is captured on the ack cycle.
  - Turnaround between cycles is at least one idle cycle.
- Bus error or timeout:
  - err_i or WB_TIMEOUT expiry sets err_sticky and abandons the cycle.
  - A read returns all-ones data.
  - The burst continues with the next word.
- LEN=0: the address is consumed, no bus cycle is issued, and the FSM returns to IDLE.
- RX inter-byte timeout: RX_TIMEOUT expiring in LEN, ADDR or WDATA drops the partial command, sets err_sticky and returns to IDLE.
- Bytes received during WB_RD or TX_WORD are discarded.
- debug_enable deasserted mid-operation:
  - The FSM goes to IDLE on the next edge and any open bus cycle is dropped (cyc=0).
  - The TX shifter resets and debug_out returns to 1.
- Ack arriving in the same cycle as timeout expiry: the ack wins and no error is flagged.

Decomposition:
- Package uartbone_pkg holds CMD_WRITE=8'h01, CMD_READ=8'h02, the FSM state enum, and the address byte count of 4.
- Sub-module uartbone_phy contains the RX synchroniser, RX and TX shifters and the baud counters, parametrised by CLK_DIV. It presents a byte-valid/byte-ready interface in both directions.

Test Plan (CLK_DIV=16, zero-wait WB slave model unless stated):
- Write 01 02 00000010 11223344 55667788 -> two WB writes, adr 0x10 data 0x11223344 then adr 0x11 data 0x55667788, sel=4'hF; err_sticky=0.
- Read 02 03 00000010, slave memory[0x10..0x12]=A0000001,A0000002,A0000003 -> 12 tx bytes A0 00 00 01 A0 00 00 02 A0 00 00 03; busy drops after the final stop bit.
- Slave never acks, read 02 01 00000020 -> cyc drops after 1024 cycles, tx bytes FF FF FF FF, err_sticky=1.
- Send 01 01 00 00 then stop -> after RX_TIMEOUT, FSM IDLE, no bus cycle, err_sticky=1; a following valid write completes normally.
- Address wrap: ADDR_WIDTH=30, write LEN=2 at 3FFFFFFF -> writes at 0x3FFFFFFF then 0x00000000.
- Bad CMD 0x55 then LEN=0 write 01 00 00000000 -> no bus cycles, busy returns to 0; deasserting debug_enable during a held cyc drops cyc next cycle and sets debug_out=1, debug_oeb=1.
